score_display_ctrl: RTL and testbench
=====================================

Name: score_display_ctrl

Overview:
- Parametrised successor to the fixed 4-digit score path (binary split plus 7-seg mux) used in the game top level.
- Accepts a binary score with a load pulse and converts it to BCD sequentially (shift-add-3, one bit per cycle).
- Drives a DIGITS-wide time-multiplexed common-anode 7-segment display with leading-zero blanking and overflow saturation.
- Sits between the game pixel/score logic and the board display pins.

Parameters:
- BIN_W, 10, width of the binary score input (1..20)
- DIGITS, 4, number of display digits (1..8)
- REFRESH_DIV, 100000, clk cycles each digit is enabled before the scan advances (>=2)
- BLANK_LZ, 1, 1 = blank leading zeros; 0 = show all digits

Ports:
- clk, in, 1, system clock
- rst, in, 1, synchronous active-low reset; the block resets on the clk edge where rst=0
- value, in, BIN_W, binary score to display
- load, in, 1, one-cycle request to convert value
- busy, out, 1, conversion in progress
- bcd_valid, out, 1, one-cycle pulse when bcd updates
- bcd, out, 4*DIGITS, converted BCD; digit 0 is bits [3:0]
- ovf, out, 1, last loaded value exceeded 10^DIGITS-1
- seg, out, [0:6], active-low segments a..g
- an, out, DIGITS, active-low one-hot digit enables

Behaviour:
- Reset values: busy=0, bcd_valid=0, bcd=0, ovf=0, pending=0, scan index=0, refresh count=0, an=~1 (digit 0 on), seg=7'b0000001 ("0").
- Converter FSM has states IDLE, SHIFT, DONE.
  - IDLE with load=1: capture value; set ovf_next=(value > 10^DIGITS-1); clear the shift register; go to SHIFT.
  - SHIFT runs exactly BIN_W cycles. Each cycle, add 3 to every BCD nibble >=5, then shift left by one and bring in the input MSB.
  - DONE: bcd <= result, or all 9s when ovf_next=1; ovf <= ovf_next; bcd_valid=1 for this cycle only; go to IDLE.
- busy=1 in SHIFT and DONE.
- Latency: load in cycle N gives bcd_valid and the new bcd in cycle N+BIN_W+1; the display reflects it from cycle N+BIN_W+2.
- Load during busy: value is stored in a one-deep pending register, and a later load overwrites it (last value wins).
  - In DONE with pending=1: FSM goes directly to SHIFT with the pending value, clears pending, and keeps busy=1.
  - No load is ever dropped except by being superseded.
- bcd holds its last value until the next DONE. Reset mid-conversion discards the conversion and the pending value.
- Internal BCD register is 4*DIGITS bits. Nibble carries out of the top digit are ignored because ovf saturation overrides the result.
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1. On wrap, scan index increments and wraps DIGITS-1 -> 0.
  - an = ~(1<<index), registered; seg is registered in the same cycle as an.
- Blanking (BLANK_LZ=1):
  - Digit i is blanked (seg=7'b1111111, an still asserted) when i > 0 and all nibbles i..DIGITS-1 are zero.
  - Digit 0 is never blanked. Blanking is never applied while ovf=1.
- Nibble values 10..15 cannot occur; if forced, they encode as "-" (7'b1111110).

Decomposition:
- Package score_disp_pkg:
  - conv_state_t enum {IDLE, SHIFT, DONE}
  - SEG_LUT, a 16-entry active-low [0:6] table
  - SEG_BLANK, SEG_DASH constants
  - function pow10(n) for the overflow limit
- Sub-module bin2bcd_seq (parameters BIN_W, DIGITS) holds the FSM, the pending register and the shift-add-3 datapath.
- The top holds the scan counter, blanking and segment encode.

Test Plan:
1. rst=0 for 3 cycles, then release -> busy=0, bcd=0, an=4'b1110, seg=7'b0000001; after REFRESH_DIV cycles an=4'b1101, seg=7'b1111111 (blanked).
2. load value=937 (BIN_W=10) at cycle N -> busy during N+1..N+11; bcd_valid only at N+11; bcd=16'h0937; scan shows 7, 3, 9, then digit 3 blank.
3. load 5, then load 812 two cycles later, then load 40 one cycle after that -> first bcd=0005, immediately followed by a second conversion; final bcd=0040; 812 never appears; exactly two bcd_valid pulses.
4. BIN_W=14, load 12345 -> ovf=1, bcd=16'h9999, no blanking; then load 0 -> ovf=0, bcd=0, only digit 0 shows "0".
5. BLANK_LZ=0, value=7 -> an scan shows 7,0,0,0 with all digits lit.
6. Assert rst=0 mid-SHIFT with a pending load -> after release busy=0, bcd=0, no bcd_valid pulse follows.

Source files
------------

// File: rtl/score_disp_pkg.sv
// score_disp_pkg: shared types, 7-segment table and helpers for the score display path.
package score_disp_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;
    typedef logic [0:6] seg_t;
    localparam seg_t SEG_BLANK = 7'b1111111;
    localparam seg_t SEG_DASH  = 7'b1111110;
    // Active-low a..g, segment a in bit 0; codes 10..15 show a dash.
    localparam seg_t SEG_LUT [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, SEG_DASH, SEG_DASH,
        SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH
    };
    function automatic logic [31:0] pow10(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 0; i < n; i++) r = r * 32'd10;
        return r;
    endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 binary to BCD converter with a one-deep pending load.
module bin2bcd_seq
    import score_disp_pkg::*;
#(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIN_W-1:0]      value,
    input  logic                  load,
    output logic                  busy,
    output logic                  bcd_valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);
    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + BIN_W;
    localparam int CW = $clog2(BIN_W + 1);
    localparam logic [31:0] LIMIT = pow10(DIGITS) - 32'd1;

    conv_state_t      r_state;
    logic [SW-1:0]    r_sh, w_adj, w_step;
    logic [CW-1:0]    r_cnt;
    logic [BIN_W-1:0] r_pend_val, w_start_val;
    logic             r_pend, r_ovf_nxt, w_start;

    // A new conversion may start from IDLE or straight out of DONE; a live load beats the pending one.
    assign w_start     = (r_state != SHIFT) && (load || r_pend);
    assign w_start_val = load ? value : r_pend_val;
    assign w_step      = {w_adj[SW-2:0], 1'b0};

    always_comb begin
        w_adj = r_sh;
        for (int i = 0; i < DIGITS; i++)
            w_adj[BIN_W+4*i +: 4] = (r_sh[BIN_W+4*i +: 4] >= 4'd5) ? r_sh[BIN_W+4*i +: 4] + 4'd3 : r_sh[BIN_W+4*i +: 4];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_sh       <= '0;
            r_cnt      <= '0;
            r_pend     <= 1'b0;
            r_pend_val <= '0;
            r_ovf_nxt  <= 1'b0;
            busy       <= 1'b0;
            bcd_valid  <= 1'b0;
            bcd        <= '0;
            ovf        <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            if (w_start) begin
                r_state   <= SHIFT;
                r_sh      <= {{BW{1'b0}}, w_start_val};
                r_cnt     <= '0;
                r_ovf_nxt <= {{(32-BIN_W){1'b0}}, w_start_val} > LIMIT;
                r_pend    <= 1'b0;
                busy      <= 1'b1;
            end else if (r_state == SHIFT) begin
                r_sh  <= w_step;
                r_cnt <= r_cnt + 1'b1;
                if (load) begin
                    r_pend     <= 1'b1;
                    r_pend_val <= value;
                end
                if (r_cnt == CW'(BIN_W - 1)) begin
                    r_state   <= DONE;
                    bcd       <= r_ovf_nxt ? {DIGITS{4'h9}} : w_step[SW-1:BIN_W];
                    ovf       <= r_ovf_nxt;
                    bcd_valid <= 1'b1;
                end
            end else begin
                r_state <= IDLE;
                busy    <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/score_display_ctrl.sv
// score_display_ctrl: binary score to multiplexed common-anode 7-segment display
// with leading-zero blanking and overflow saturation.
module score_display_ctrl
    import score_disp_pkg::*;
#(
    parameter int BIN_W       = 10,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_LZ    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIN_W-1:0]      value,
    input  logic                  load,
    output logic                  busy,
    output logic                  bcd_valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf,
    output logic [0:6]            seg,
    output logic [DIGITS-1:0]     an
);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = DIGITS > 1 ? $clog2(DIGITS) : 1;

    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx, w_idx_nxt;
    logic [DIGITS-1:0] w_zero;
    logic [3:0]        w_nib;
    logic              w_wrap, w_blank;

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) u_conv (
        .clk       (clk),
        .rst       (rst),
        .value     (value),
        .load      (load),
        .busy      (busy),
        .bcd_valid (bcd_valid),
        .bcd       (bcd),
        .ovf       (ovf)
    );

    // w_zero[i]: digit i and every digit above it are zero.
    for (genvar g = 0; g < DIGITS; g++) begin : g_zero
        assign w_zero[g] = (bcd >> (4 * g)) == '0;
    end

    // an/seg are registered from the next index so they switch together with the scan index.
    assign w_wrap    = r_cnt == CNT_W'(REFRESH_DIV - 1);
    assign w_idx_nxt = !w_wrap ? r_idx : (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
    assign w_nib     = bcd[4*w_idx_nxt +: 4];
    assign w_blank   = (BLANK_LZ != 0) && !ovf && (w_idx_nxt != '0) && w_zero[w_idx_nxt];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
            r_idx <= '0;
            an    <= ~DIGITS'(1);
            seg   <= SEG_LUT[0];
        end else begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            r_idx <= w_idx_nxt;
            an    <= ~(DIGITS'(1) << w_idx_nxt);
            seg   <= w_blank ? SEG_BLANK : SEG_LUT[w_nib];
        end
    end
endmodule

// File: tb/tb_score_display_ctrl.sv
// tb_score_display_ctrl: directed checks of conversion latency, pending loads,
// overflow saturation, blanking and scan order.
module tb_score_display_ctrl;
    localparam int RD = 4;
    localparam logic [6:0] S0 = 7'b0000001, S3 = 7'b0000110, S7 = 7'b0001111;
    localparam logic [6:0] S9 = 7'b0000100, SB = 7'b1111111;

    logic clk = 1'b0, rst = 1'b0;
    always #5 clk = ~clk;

    logic [9:0]  a_value = '0, c_value = '0;
    logic [13:0] b_value = '0;
    logic        a_load = 1'b0, b_load = 1'b0, c_load = 1'b0;
    logic        a_busy, b_busy, c_busy, a_valid, b_valid, c_valid, a_ovf, b_ovf, c_ovf;
    logic [15:0] a_bcd, b_bcd, c_bcd;
    logic [0:6]  a_seg, b_seg, c_seg;
    logic [3:0]  a_an, b_an, c_an;

    int n_checks = 0, n_fail = 0, a_pulses = 0;

    score_display_ctrl #(.BIN_W(10), .DIGITS(4), .REFRESH_DIV(RD), .BLANK_LZ(1)) u_a (
        .clk(clk), .rst(rst), .value(a_value), .load(a_load), .busy(a_busy),
        .bcd_valid(a_valid), .bcd(a_bcd), .ovf(a_ovf), .seg(a_seg), .an(a_an));
    score_display_ctrl #(.BIN_W(14), .DIGITS(4), .REFRESH_DIV(RD), .BLANK_LZ(1)) u_b (
        .clk(clk), .rst(rst), .value(b_value), .load(b_load), .busy(b_busy),
        .bcd_valid(b_valid), .bcd(b_bcd), .ovf(b_ovf), .seg(b_seg), .an(b_an));
    score_display_ctrl #(.BIN_W(10), .DIGITS(4), .REFRESH_DIV(RD), .BLANK_LZ(0)) u_c (
        .clk(clk), .rst(rst), .value(c_value), .load(c_load), .busy(c_busy),
        .bcd_valid(c_valid), .bcd(c_bcd), .ovf(c_ovf), .seg(c_seg), .an(c_an));

    always @(posedge clk) if (a_valid) a_pulses++;

    // Observes one full scan and records the segment pattern seen for each digit.
    task automatic collect(input int sel, output logic [3:0][6:0] segs, output logic [3:0] seen, output logic bad);
        logic [3:0] an;
        logic [6:0] sg;
        segs = '0;
        seen = '0;
        bad  = 1'b0;
        for (int k = 0; k < 4 * RD + 1; k++) begin
            @(negedge clk);
            an = sel == 0 ? a_an : sel == 1 ? b_an : c_an;
            sg = sel == 0 ? a_seg : sel == 1 ? b_seg : c_seg;
            if (!$onehot(~an)) bad = 1'b1;
            for (int d = 0; d < 4; d++)
                if (an == ~(4'b1 << d)) begin
                    seen[d] = 1'b1;
                    segs[d] = sg;
                end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", a_busy); end
        n_checks++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", a_valid); end
        n_checks++; if (a_bcd !== 16'h0) begin n_fail++; $display("FAIL reset_bcd: got %h want 0000", a_bcd); end
        n_checks++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", a_ovf); end
        n_checks++; if (a_an !== 4'b1110) begin n_fail++; $display("FAIL reset_an: got %b want 1110", a_an); end
        n_checks++; if (a_seg !== S0) begin n_fail++; $display("FAIL reset_seg: got %b want %b", a_seg, S0); end
        rst = 1'b1;
        repeat (RD - 1) @(negedge clk);
        n_checks++; if (a_an !== 4'b1110) begin n_fail++; $display("FAIL scan_hold_an: got %b want 1110", a_an); end
        @(negedge clk);
        n_checks++; if (a_an !== 4'b1101) begin n_fail++; $display("FAIL scan_adv_an: got %b want 1101", a_an); end
        n_checks++; if (a_seg !== SB) begin n_fail++; $display("FAIL scan_adv_seg: got %b want %b", a_seg, SB); end
    endtask

    task automatic test_convert;
        int p0;
        logic [3:0][6:0] segs, exp_segs;
        logic [3:0] seen;
        logic bad;
        @(negedge clk);
        p0 = a_pulses;
        a_value = 10'd937;
        a_load = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            a_load = 1'b0;
            n_checks++; if (a_busy !== (k <= 11)) begin n_fail++; $display("FAIL conv_busy[%0d]: got %b want %b", k, a_busy, k <= 11); end
            n_checks++; if (a_valid !== (k == 11)) begin n_fail++; $display("FAIL conv_valid[%0d]: got %b want %b", k, a_valid, k == 11); end
            if (k == 11) begin
                n_checks++; if (a_bcd !== 16'h0937) begin n_fail++; $display("FAIL conv_bcd: got %h want 0937", a_bcd); end
                n_checks++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL conv_ovf: got %b want 0", a_ovf); end
            end
        end
        n_checks++; if (a_pulses - p0 !== 1) begin n_fail++; $display("FAIL conv_pulses: got %0d want 1", a_pulses - p0); end
        collect(0, segs, seen, bad);
        exp_segs = {SB, S9, S3, S7};
        n_checks++; if (seen !== 4'hF || bad) begin n_fail++; $display("FAIL conv_scan_an: seen %b bad %b want 1111 0", seen, bad); end
        for (int d = 0; d < 4; d++) begin
            n_checks++; if (segs[d] !== exp_segs[d]) begin n_fail++; $display("FAIL conv_seg[%0d]: got %b want %b", d, segs[d], exp_segs[d]); end
        end
    endtask

    task automatic test_back_to_back;
        int p0, v1, v2;
        logic [15:0] b1, b2;
        bit saw812;
        v1 = -1; v2 = -1; b1 = '0; b2 = '0; saw812 = 0;
        p0 = a_pulses;
        for (int k = 0; k <= 30; k++) begin
            if (k > 0) begin
                if (a_bcd === 16'h0812) saw812 = 1;
                if (a_valid === 1'b1) begin
                    if (v1 < 0) begin v1 = k; b1 = a_bcd; end
                    else begin v2 = k; b2 = a_bcd; end
                end
            end
            a_load  = (k == 0 || k == 2 || k == 3);
            a_value = k == 0 ? 10'd5 : k == 2 ? 10'd812 : k == 3 ? 10'd40 : a_value;
            @(negedge clk);
        end
        n_checks++; if (v1 !== 11) begin n_fail++; $display("FAIL b2b_first_time: got %0d want 11", v1); end
        n_checks++; if (b1 !== 16'h0005) begin n_fail++; $display("FAIL b2b_first_bcd: got %h want 0005", b1); end
        n_checks++; if (v2 !== 22) begin n_fail++; $display("FAIL b2b_second_time: got %0d want 22", v2); end
        n_checks++; if (b2 !== 16'h0040) begin n_fail++; $display("FAIL b2b_second_bcd: got %h want 0040", b2); end
        n_checks++; if (a_pulses - p0 !== 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 2", a_pulses - p0); end
        n_checks++; if (saw812) begin n_fail++; $display("FAIL b2b_superseded: got 0812 shown want never"); end
        n_checks++; if (a_bcd !== 16'h0040) begin n_fail++; $display("FAIL b2b_final: got %h want 0040", a_bcd); end
    endtask

    task automatic test_overflow;
        logic [13:0] vals [4];
        logic [15:0] ebcd [4];
        logic        eovf [4];
        logic [3:0][6:0] segs, exp_segs;
        logic [3:0] seen;
        logic bad;
        int hit;
        vals = '{14'd12345, 14'd9999, 14'd10000, 14'd0};
        ebcd = '{16'h9999, 16'h9999, 16'h9999, 16'h0000};
        eovf = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            b_value = vals[i];
            b_load = 1'b1;
            hit = -1;
            for (int k = 1; k <= 20 && hit < 0; k++) begin
                @(negedge clk);
                b_load = 1'b0;
                if (b_valid === 1'b1) hit = k;
            end
            n_checks++; if (hit !== 15) begin n_fail++; $display("FAIL ovf_latency[%0d]: got %0d want 15", i, hit); end
            n_checks++; if (b_bcd !== ebcd[i]) begin n_fail++; $display("FAIL ovf_bcd[%0d]: got %h want %h", i, b_bcd, ebcd[i]); end
            n_checks++; if (b_ovf !== eovf[i]) begin n_fail++; $display("FAIL ovf_flag[%0d]: got %b want %b", i, b_ovf, eovf[i]); end
            if (i == 0 || i == 3) begin
                collect(1, segs, seen, bad);
                exp_segs = (i == 0) ? {S9, S9, S9, S9} : {SB, SB, SB, S0};
                n_checks++; if (seen !== 4'hF || bad) begin n_fail++; $display("FAIL ovf_scan_an[%0d]: seen %b bad %b want 1111 0", i, seen, bad); end
                for (int d = 0; d < 4; d++) begin
                    n_checks++; if (segs[d] !== exp_segs[d]) begin n_fail++; $display("FAIL ovf_seg[%0d][%0d]: got %b want %b", i, d, segs[d], exp_segs[d]); end
                end
            end
        end
    endtask

    task automatic test_no_blank;
        logic [3:0][6:0] segs, exp_segs;
        logic [3:0] seen;
        logic bad;
        int hit;
        c_value = 10'd7;
        c_load = 1'b1;
        hit = -1;
        for (int k = 1; k <= 20 && hit < 0; k++) begin
            @(negedge clk);
            c_load = 1'b0;
            if (c_valid === 1'b1) hit = k;
        end
        n_checks++; if (hit !== 11) begin n_fail++; $display("FAIL nb_latency: got %0d want 11", hit); end
        n_checks++; if (c_bcd !== 16'h0007) begin n_fail++; $display("FAIL nb_bcd: got %h want 0007", c_bcd); end
        collect(2, segs, seen, bad);
        exp_segs = {S0, S0, S0, S7};
        n_checks++; if (seen !== 4'hF || bad) begin n_fail++; $display("FAIL nb_scan_an: seen %b bad %b want 1111 0", seen, bad); end
        for (int d = 0; d < 4; d++) begin
            n_checks++; if (segs[d] !== exp_segs[d]) begin n_fail++; $display("FAIL nb_seg[%0d]: got %b want %b", d, segs[d], exp_segs[d]); end
        end
    endtask

    task automatic test_reset_mid;
        int p0;
        bit busy_seen;
        busy_seen = 0;
        a_value = 10'd100;
        a_load = 1'b1;
        @(negedge clk);
        a_load = 1'b0;
        repeat (2) @(negedge clk);
        a_value = 10'd200;
        a_load = 1'b1;
        @(negedge clk);
        a_load = 1'b0;
        n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_busy: got %b want 1", a_busy); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        p0 = a_pulses;
        n_checks++; if (a_bcd !== 16'h0) begin n_fail++; $display("FAIL rmid_bcd: got %h want 0000", a_bcd); end
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (a_busy !== 1'b0) busy_seen = 1;
        end
        n_checks++; if (busy_seen) begin n_fail++; $display("FAIL rmid_busy: got 1 want 0"); end
        n_checks++; if (a_pulses - p0 !== 0) begin n_fail++; $display("FAIL rmid_pulses: got %0d want 0", a_pulses - p0); end
        n_checks++; if (a_bcd !== 16'h0) begin n_fail++; $display("FAIL rmid_bcd_after: got %h want 0000", a_bcd); end
    endtask

    initial begin
        test_reset;
        test_convert;
        test_back_to_back;
        test_overflow;
        test_no_blank;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
